// File: rtl/riscv_apu_arbiter.sv
// Round-robin arbiter sharing one APU among several cores. It keeps an in-order tag FIFO
// so that each result is returned to the core whose request the APU accepted.
module riscv_apu_arbiter #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned PAYLOAD_W = 96,
  parameter int unsigned RESULT_W  = 32,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_CORES-1:0]           core_req_i,
  input  logic [NUM_CORES*PAYLOAD_W-1:0] core_payload_i,
  output logic [NUM_CORES-1:0]           core_gnt_o,
  output logic [NUM_CORES-1:0]           core_valid_o,
  output logic [RESULT_W-1:0]            core_result_o,
  output logic                           apu_req_o,
  output logic [PAYLOAD_W-1:0]           apu_payload_o,
  input  logic                           apu_gnt_i,
  input  logic                           apu_valid_i,
  input  logic [RESULT_W-1:0]            apu_result_i,
  output logic                           busy_o,
  output logic                           err_o
);

  localparam int unsigned IdxW = $clog2(NUM_CORES);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [IdxW:0]   NumCores = (IdxW + 1)'(NUM_CORES);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(NUM_CORES - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  logic [IdxW-1:0] rr_q, rr_d;
  logic [IdxW-1:0] winner, head;
  logic [IdxW:0]   cand;
  logic            found;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            err_q, err_d;
  logic [IdxW-1:0] tags_q [DEPTH];
  logic            full, empty, accept, push, pop, bypass;

  // Search upward from rr_q with wrap-around and take the first core that requests.
  always_comb begin
    winner = rr_q;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      cand = {1'b0, rr_q} + (IdxW + 1)'(k);
      if (cand >= NumCores) cand = cand - NumCores;
      if (!found && core_req_i[cand[IdxW-1:0]]) begin
        winner = cand[IdxW-1:0];
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    apu_payload_o = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (found && winner == IdxW'(i)) apu_payload_o = core_payload_i[i*PAYLOAD_W +: PAYLOAD_W];
    end
  end

  assign full      = (count_q == DepthCnt);
  assign empty     = (count_q == '0);
  assign apu_req_o = found & ~full;
  assign accept    = apu_req_o & apu_gnt_i;
  assign head      = tags_q[rd_ptr_q];

  // A result that meets an empty FIFO together with an accept belongs to this very request.
  assign pop    = apu_valid_i & ~empty;
  assign bypass = apu_valid_i & empty & accept;
  assign push   = accept & ~bypass;

  assign core_gnt_o    = accept ? (NUM_CORES'(1) << winner) : '0;
  assign core_result_o = apu_result_i;
  assign busy_o        = ~empty;
  assign err_o         = err_q;

  always_comb begin
    core_valid_o = '0;
    if (pop) begin
      core_valid_o = NUM_CORES'(1) << head;
    end else if (bypass) begin
      core_valid_o = NUM_CORES'(1) << winner;
    end
  end

  always_comb begin
    rr_d     = rr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q | (apu_valid_i & empty & ~accept);
    if (accept) rr_d = (winner == LastIdx) ? '0 : winner + 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_q     <= rr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Tag storage needs no reset: count_q and the pointers gate every read.
  always_ff @(posedge clk_i) begin
    if (push) tags_q[wr_ptr_q] <= winner;
  end

endmodule

// File: tb/tb_riscv_apu_arbiter.sv
// Directed scoreboard bench for riscv_apu_arbiter: the stimulus queues the expected grants and
// results, and the monitor pops one entry each time the DUT drives a grant or a result.
module tb_riscv_apu_arbiter;

  typedef struct packed {
    logic [3:0]  oh;
    logic [31:0] res;
  } vexp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   core_req;
  logic [383:0] core_payload;
  logic [3:0]   core_gnt, core_valid;
  logic [31:0]  core_result;
  logic         apu_req;
  logic [95:0]  apu_payload;
  logic         apu_gnt, apu_valid;
  logic [31:0]  apu_result;
  logic         busy, err;

  logic [95:0]  pay [4];
  logic [3:0]   gq [$];
  vexp_t        vq [$];
  int           n_vec = 0;
  int           n_miss = 0;
  int           res_cnt = 0;

  always #5 clk = ~clk;

  riscv_apu_arbiter #(
    .NUM_CORES(4),
    .PAYLOAD_W(96),
    .RESULT_W (32),
    .DEPTH    (4)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .core_req_i    (core_req),
    .core_payload_i(core_payload),
    .core_gnt_o    (core_gnt),
    .core_valid_o  (core_valid),
    .core_result_o (core_result),
    .apu_req_o     (apu_req),
    .apu_payload_o (apu_payload),
    .apu_gnt_i     (apu_gnt),
    .apu_valid_i   (apu_valid),
    .apu_result_i  (apu_result),
    .busy_o        (busy),
    .err_o         (err)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int oh2i(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return i;
    return 0;
  endfunction

  // One clock of stimulus: r/req/g/v drive the DUT; eg/ev are the expected grant and valid
  // one-hots; eb/ee/ea the expected busy, err and apu_req in this cycle.
  task automatic cyc(input logic r, input logic [3:0] req, input logic g, input logic v,
                     input logic [3:0] eg, input logic [3:0] ev,
                     input logic eb, input logic ee, input logic ea);
    vexp_t e;
    rst       = r;
    core_req  = req;
    apu_gnt   = g;
    apu_valid = v;
    res_cnt++;
    apu_result = 32'hA000_0000 + 32'(res_cnt);
    if (eg != 4'b0) gq.push_back(eg);
    if (ev != 4'b0) begin
      e.oh  = ev;
      e.res = apu_result;
      vq.push_back(e);
    end
    @(negedge clk);
    chk("busy", 128'(busy), 128'(eb));
    chk("err", 128'(err), 128'(ee));
    chk("apu_req", 128'(apu_req), 128'(ea));
    @(posedge clk);
    #1;
  endtask

  // Monitor
  initial begin
    logic [3:0] g;
    vexp_t      e;
    forever begin
      @(negedge clk);
      if (core_gnt != 4'b0) begin
        if (gq.size() == 0) begin
          chk("unexpected_gnt", 128'(core_gnt), 128'(0));
        end else begin
          g = gq.pop_front();
          chk("gnt", 128'(core_gnt), 128'(g));
          chk("payload", 128'(apu_payload), 128'(pay[oh2i(g)]));
        end
      end
      if (core_valid != 4'b0) begin
        if (vq.size() == 0) begin
          chk("unexpected_valid", 128'(core_valid), 128'(0));
        end else begin
          e = vq.pop_front();
          chk("valid", 128'(core_valid), 128'(e.oh));
          chk("result", 128'(core_result), 128'(e.res));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      pay[i] = {32'hC0DE_0000 + 32'(i), 32'h1111_1111 * 32'(i + 1), 32'hF0F0_0000 | 32'(i)};
      core_payload[i*96 +: 96] = pay[i];
    end
    rst = 1'b1; core_req = '0; apu_gnt = 1'b0; apu_valid = 1'b0; apu_result = '0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_gnt", 128'(core_gnt), 128'(0));
    chk("rst_valid", 128'(core_valid), 128'(0));
    chk("rst_apu_req", 128'(apu_req), 128'(0));
    chk("rst_payload", 128'(apu_payload), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    @(posedge clk);
    #1;

    // All cores request, results two cycles after each accept.
    cyc(0, 4'hF, 1, 0, 4'h1, 4'h0, 0, 0, 1);
    cyc(0, 4'hF, 1, 0, 4'h2, 4'h0, 1, 0, 1);
    cyc(0, 4'hF, 1, 1, 4'h4, 4'h1, 1, 0, 1);
    cyc(0, 4'hF, 1, 1, 4'h8, 4'h2, 1, 0, 1);
    cyc(0, 4'hF, 1, 1, 4'h1, 4'h4, 1, 0, 1);
    cyc(0, 4'hF, 1, 1, 4'h2, 4'h8, 1, 0, 1);
    cyc(0, 4'hF, 1, 1, 4'h4, 4'h1, 1, 0, 1);
    cyc(0, 4'hF, 1, 1, 4'h8, 4'h2, 1, 0, 1);
    cyc(0, 4'h0, 0, 1, 4'h0, 4'h4, 1, 0, 0);
    cyc(0, 4'h0, 0, 1, 4'h0, 4'h8, 1, 0, 0);
    cyc(0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0, 0);

    // Fill: cores 1 and 2 until full, one result frees a slot, then drain.
    cyc(0, 4'h6, 1, 0, 4'h2, 4'h0, 0, 0, 1);
    cyc(0, 4'h6, 1, 0, 4'h4, 4'h0, 1, 0, 1);
    cyc(0, 4'h6, 1, 0, 4'h2, 4'h0, 1, 0, 1);
    cyc(0, 4'h6, 1, 0, 4'h4, 4'h0, 1, 0, 1);
    cyc(0, 4'h6, 1, 0, 4'h0, 4'h0, 1, 0, 0);
    cyc(0, 4'h6, 1, 0, 4'h0, 4'h0, 1, 0, 0);
    cyc(0, 4'h6, 1, 1, 4'h0, 4'h2, 1, 0, 0);
    cyc(0, 4'h6, 1, 0, 4'h2, 4'h0, 1, 0, 1);
    cyc(0, 4'h0, 0, 1, 4'h0, 4'h4, 1, 0, 0);
    cyc(0, 4'h0, 0, 1, 4'h0, 4'h2, 1, 0, 0);
    cyc(0, 4'h0, 0, 1, 4'h0, 4'h4, 1, 0, 0);
    cyc(0, 4'h0, 0, 1, 4'h0, 4'h2, 1, 0, 0);
    cyc(0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0, 0);

    // Bypass: empty FIFO, accept and result in the same cycle.
    cyc(0, 4'h8, 1, 1, 4'h8, 4'h8, 0, 0, 1);
    cyc(0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0, 0);

    // Back-pressure: cores 0 and 2 stalled for three cycles.
    cyc(0, 4'h5, 0, 0, 4'h0, 4'h0, 0, 0, 1);
    cyc(0, 4'h5, 0, 0, 4'h0, 4'h0, 0, 0, 1);
    cyc(0, 4'h5, 0, 0, 4'h0, 4'h0, 0, 0, 1);
    cyc(0, 4'h5, 1, 0, 4'h1, 4'h0, 0, 0, 1);
    cyc(0, 4'h5, 1, 0, 4'h4, 4'h0, 1, 0, 1);
    cyc(0, 4'h0, 0, 1, 4'h0, 4'h1, 1, 0, 0);
    cyc(0, 4'h0, 0, 1, 4'h0, 4'h4, 1, 0, 0);
    cyc(0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0, 0);

    // Spurious result while idle.
    cyc(0, 4'h0, 0, 1, 4'h0, 4'h0, 0, 0, 0);
    cyc(0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 1, 0);
    cyc(0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 1, 0);

    // Reset with three outstanding; priority and error state must restart.
    cyc(0, 4'hF, 1, 0, 4'h8, 4'h0, 0, 1, 1);
    cyc(0, 4'hF, 1, 0, 4'h1, 4'h0, 1, 1, 1);
    cyc(0, 4'hF, 1, 0, 4'h2, 4'h0, 1, 1, 1);
    cyc(1, 4'h0, 0, 0, 4'h0, 4'h0, 1, 1, 0);
    cyc(0, 4'h4, 1, 0, 4'h4, 4'h0, 0, 0, 1);
    cyc(0, 4'h0, 0, 1, 4'h0, 4'h4, 1, 0, 0);
    cyc(0, 4'h0, 0, 1, 4'h0, 4'h0, 0, 0, 0);
    cyc(0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 1, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("gnt_queue_drained", 128'(gq.size()), 128'(0));
    chk("valid_queue_drained", 128'(vq.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/riscv_apu_arbiter.md
# riscv_apu_arbiter

Shares one APU (FPU/DSP unit) between NUM_CORES riscv cores. Each core's APU dispatcher presents requests here. The block picks one requester per cycle by round-robin, forwards its payload to the shared unit, and records the winner's core index in an in-order tag FIFO. Results from the shared unit are steered back to the recorded core. It sits at cluster level, between the per-core dispatchers and the shared APU interconnect port.

## Interface
- NUM_CORES, 4: number of requesting cores (2..8).
- PAYLOAD_W, 96: width of the request payload (operands, opcode, flags).
- RESULT_W, 32: width of the result returned by the shared unit.
- DEPTH, 4: maximum number of outstanding accepted requests (power of 2, ≥2).
- clk_i  in  1  single clock.
- rst_i  in  1  reset; one clock; reset is synchronous and active-high.
- core_req_i  in  NUM_CORES  per-core request.
- core_payload_i  in  NUM_CORES×PAYLOAD_W  per-core payload.
- core_gnt_o  out  NUM_CORES  one-hot grant.
- core_valid_o  out  NUM_CORES  one-hot result valid.
- core_result_o  out  RESULT_W  result, broadcast to all cores.
- apu_req_o  out  1  request to the shared unit.
- apu_payload_o  out  PAYLOAD_W  payload of the selected core.
- apu_gnt_i  in  1  shared unit accepts apu_req_o.
- apu_valid_i  in  1  result valid; results return in acceptance order.
- apu_result_i  in  RESULT_W  result data.
- busy_o  out  1  at least one request outstanding.
- err_o  out  1  sticky: a result arrived with nothing outstanding.

## Operation
- Round-robin pointer rr_q (0..NUM_CORES-1). The winner is the first core with core_req_i set, searching from rr_q upward with wrap-around.
- full = (count_q == DEPTH). apu_req_o = |core_req_i & !full. apu_payload_o = payload of the winner; it is all zeros when there is no winner.
- Accept = apu_req_o & apu_gnt_i. On accept: core_gnt_o[winner] = 1, and rr_q <= winner+1 mod NUM_CORES. With no accept, rr_q holds. core_gnt_o is zero while full, even if apu_gnt_i is high.
- Tag FIFO holds core indices, with read pointer, write pointer and count_q. On accept, the winner index is pushed, except in the bypass case below.
- Result routing when apu_valid_i = 1:
  - If FIFO is non-empty: core_valid_o[head] = 1 and the head is popped.
  - If FIFO is empty and accept occurs in the same cycle (single-cycle op): this is the bypass case. core_valid_o[winner] = 1 and nothing is pushed.
  - If FIFO is empty and there is no accept: core_valid_o = 0 and err_o <= 1 (sticky until reset).
- Accept and pop in the same cycle with the FIFO non-empty: push the winner and pop the head. count_q is unchanged.
- A pop while full frees the slot only from the next cycle. No same-cycle push while full.
- core_result_o = apu_result_i, unconditionally.
- busy_o = (count_q != 0).

## Timing
- Grant, payload mux, result routing and bypass are combinational from inputs and registered state. There are zero added cycles on either the request or the response path.
- Registered state: rr_q, FIFO pointers, count_q, err_o. All update on the rising edge of clk_i.
- Reset (rst_i high at an edge): rr_q=0, pointers=0, count_q=0, err_o=0. Outstanding tags are discarded, and results arriving after reset count as spurious (err_o).
- Outputs during and after reset with all inputs low: core_gnt_o=0, core_valid_o=0, apu_req_o=0, apu_payload_o=0, busy_o=0, err_o=0.
- A requester held off by apu_gnt_i=0 keeps its priority: rr_q does not move without an accept.
- Fairness: with all cores requesting continuously and apu_gnt_i=1, each core is granted exactly once every NUM_CORES accepts.

## Test plan
- Reset, then all four cores request continuously, apu_gnt_i=1, results returned 2 cycles after each accept. Required: grants follow core 0,1,2,3,0…; each core_valid_o matches its grant order; count_q never exceeds 2; err_o=0.
- Fill: cores 1 and 2 request, apu_gnt_i=1, apu_valid_i=0. Required: 4 accepts, then apu_req_o=0 and core_gnt_o=0 while count_q=4. One apu_valid_i returns to core 1 (the first accepted), and the next cycle one grant resumes.
- Bypass: FIFO empty, core 3 requests, apu_gnt_i=1 and apu_valid_i=1 in the same cycle. Required: core_gnt_o=4'b1000, core_valid_o=4'b1000, busy_o stays 0.
- Back-pressure: cores 0 and 2 request, apu_gnt_i=0 for 3 cycles, then 1. Required: no grant during the stall; rr_q stays 0; core 0 is granted first, then core 2.
- Spurious result: idle, apu_valid_i=1 for one cycle. Required: core_valid_o=0, err_o=1 from the next cycle, held until rst_i.
- Reset mid-operation: 3 outstanding, then rst_i pulsed. Required: busy_o=0 and rr_q=0 after the reset edge; the next request from core 2 is granted immediately.
